// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter: default sizes, counter width,
// and FSM state encodings.
package mem_port_arbiter_pkg;

  localparam int unsigned DefAw  = 10;
  localparam int unsigned DefDw  = 32;
  localparam int unsigned DefLat = 2;
  // Wide enough for the largest legal latency (7).
  localparam int unsigned CntW   = 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StAck  = 2'd2
  } state_e;

endpackage

// File: rtl/mux2to1_10.sv
// Shared 10-bit 2:1 address mux: y = sel ? b : a.
module mux2to1_10 (
  input  logic [9:0] a,
  input  logic [9:0] b,
  input  logic       sel,
  output logic [9:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between fetch (req0) and data (req1), times the fixed
// memory latency and returns ack/rdata. Define ARB_RR_EN for round-robin tie-break.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW  = DefAw,
  parameter int unsigned DW  = DefDw,
  parameter int unsigned LAT = DefLat
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic          we1,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_sel,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy
);

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              last_gnt_q;
  logic              sel_q;
  logic              we_q;
  logic              any_req;
  logic              winner;
  logic [AW-1:0]     mux_out;

  always_comb begin
    any_req = req0 | req1;
`ifdef ARB_RR_EN
    if (req0 && req1) begin
      winner = ~last_gnt_q;
    end else begin
      winner = req1;
    end
`else
    winner = req1;
`endif
  end

`ifndef ARB_RR_EN
  // Grant history is tracked in both builds but only steers ties under round-robin.
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt_q;
`endif

  // Nothing is sampled while reset is asserted, so the mux select stays low then too.
  assign mem_sel = (state_q == StIdle) ? (rst_n & winner) : sel_q;
  assign busy    = (state_q != StIdle);

  mux2to1_10 u_addr_mux (
    .a   (addr0),
    .b   (addr1),
    .sel (mem_sel),
    .y   (mux_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      last_gnt_q <= 1'b1;
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata      <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            sel_q      <= winner;
            mem_addr   <= mux_out;
            mem_wdata  <= wdata1;
            mem_we     <= we1 & winner;
            we_q       <= we1 & winner;
            mem_en     <= 1'b1;
            cnt_q      <= CntW'(LAT);
            last_gnt_q <= winner;
            state_q    <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            if (!we_q) begin
              rdata <= mem_rdata;
            end
            ack0    <= ~sel_q;
            ack1    <= sel_q;
            state_q <= StAck;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StAck: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (LAT=2); expectations follow ARB_RR_EN.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we1;
  logic [9:0]  addr0, addr1;
  logic [31:0] wdata1, mem_rdata;
  logic        mem_sel, mem_en, mem_we, ack0, ack1, busy;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, rdata;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(
    .AW  (10),
    .DW  (32),
    .LAT (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .addr0     (addr0),
    .req1      (req1),
    .addr1     (addr1),
    .we1       (we1),
    .wdata1    (wdata1),
    .mem_rdata (mem_rdata),
    .mem_sel   (mem_sel),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata     (rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({mem_sel, mem_en, mem_we, ack0, ack1, busy}), 64'd0);
    check({tag, "_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_rdata"}, 64'(rdata), 64'd0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 16; i++) begin
      if (!busy) break;
      tick();
    end
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  // Call in an IDLE cycle (cycle 0); returns in cycle 5 with req0 dropped.
  task automatic do_fetch(input string tag, input logic [9:0] a, input logic [31:0] d);
    req0  = 1'b1;
    addr0 = a;
    tick();
    check({tag, "_en"}, 64'(mem_en), 64'd1);
    check({tag, "_sel"}, 64'(mem_sel), 64'd0);
    check({tag, "_addr"}, 64'(mem_addr), 64'(a));
    check({tag, "_we"}, 64'(mem_we), 64'd0);
    tick();
    check({tag, "_en_drop"}, 64'(mem_en), 64'd0);
    tick();
    mem_rdata = d;
    check({tag, "_early_ack"}, 64'(ack0), 64'd0);
    tick();
    check({tag, "_ack"}, 64'({ack0, ack1}), 64'b10);
    check({tag, "_rdata"}, 64'(rdata), 64'(d));
    req0      = 1'b0;
    mem_rdata = '0;
    tick();
    check({tag, "_ack_pulse"}, 64'(ack0), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic first_gnt;
    logic exp_g;
`ifdef ARB_RR_EN
    first_gnt = 1'b0;
`else
    first_gnt = 1'b1;
`endif
    rst_n     = 1'b0;
    req0      = 1'b1;
    req1      = 1'b1;
    we1       = 1'b0;
    addr0     = 10'h011;
    addr1     = 10'h022;
    wdata1    = '0;
    mem_rdata = '0;

    // Reset held with both requests pending.
    tick();
    check_all_zero("rst1");
    tick();
    check_all_zero("rst2");
    rst_n = 1'b1;
    tick();
    check("rst_first_en", 64'(mem_en), 64'd1);
    check("rst_first_sel", 64'(mem_sel), 64'(first_gnt));
    check("rst_first_busy", 64'(busy), 64'd1);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_idle();

    do_fetch("fetch", 10'h155, 32'hDEADBEEF);

    // Write from requester 1 leaves rdata untouched.
    req1   = 1'b1;
    we1    = 1'b1;
    addr1  = 10'h3FF;
    wdata1 = 32'h0000_00A5;
    tick();
    check("wr_en", 64'(mem_en), 64'd1);
    check("wr_we", 64'(mem_we), 64'd1);
    check("wr_sel", 64'(mem_sel), 64'd1);
    check("wr_addr", 64'(mem_addr), 64'h3FF);
    check("wr_wdata", 64'(mem_wdata), 64'hA5);
    tick();
    check("wr_we_drop", 64'({mem_en, mem_we}), 64'd0);
    tick();
    mem_rdata = 32'h1234_5678;
    tick();
    check("wr_ack", 64'({ack0, ack1}), 64'b01);
    check("wr_rdata_kept", 64'(rdata), 64'hDEADBEEF);
    req1      = 1'b0;
    we1       = 1'b0;
    mem_rdata = '0;
    tick();
    check("wr_idle", 64'(busy), 64'd0);

    // Contention: last grant was 1, so round-robin starts with 0.
    req0  = 1'b1;
    req1  = 1'b1;
    addr0 = 10'h0F0;
    addr1 = 10'h10F;
    tick();
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      exp_g = (k % 2 == 1);
`else
      exp_g = 1'b1;
`endif
      check($sformatf("cont%0d_en", k), 64'(mem_en), 64'd1);
      check($sformatf("cont%0d_sel", k), 64'(mem_sel), 64'(exp_g));
      check($sformatf("cont%0d_addr", k), 64'(mem_addr), exp_g ? 64'h10F : 64'h0F0);
      tick();
      tick();
      tick();
      check($sformatf("cont%0d_ack", k), 64'({ack0, ack1}), exp_g ? 64'b01 : 64'b10);
      if (k == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      tick();
      tick();
    end
    check("cont_end_idle", 64'({busy, mem_en}), 64'd0);

    // Reset in cycle 2 of a fetch aborts it.
    req0  = 1'b1;
    addr0 = 10'h0AA;
    tick();
    check("abort_en", 64'(mem_en), 64'd1);
    tick();
    rst_n = 1'b0;
    req0  = 1'b0;
    tick();
    check_all_zero("abort");
    rst_n = 1'b1;
    tick();
    check("abort_no_ack", 64'({ack0, ack1, busy}), 64'd0);
    tick();
    check("abort_no_ack2", 64'({ack0, ack1, busy}), 64'd0);
    do_fetch("post_abort", 10'h2C3, 32'h0BAD_F00D);

    // Request dropped in cycle 2 still completes, with no follow-on grant.
    req0  = 1'b1;
    addr0 = 10'h1E1;
    tick();
    check("drop_en", 64'(mem_en), 64'd1);
    tick();
    req0 = 1'b0;
    tick();
    mem_rdata = 32'hCAFE_F00D;
    tick();
    check("drop_ack", 64'({ack0, ack1}), 64'b10);
    check("drop_rdata", 64'(rdata), 64'hCAFEF00D);
    mem_rdata = '0;
    tick();
    check("drop_idle", 64'(busy), 64'd0);
    tick();
    check("drop_no_regrant", 64'({busy, mem_en}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
